// File: rtl/rf_pkg.sv
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared constants, write-port type and write-qualify helper for
//            the multi-port register file.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int unsigned c_DATA_W = 16;
    localparam int unsigned c_ADDR_W = 4;

    typedef struct packed {
        logic                en;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } wr_port_t;

    // A write (or issue) to r0 is discarded when r0 is hardwired to zero.
    function automatic logic is_eff_write(input logic        en,
                                          input logic [31:0] addr,
                                          input logic        zero_reg);
        return en && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Per-register pending bits: set on issue, cleared on writeback,
//            all cleared on flush.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = c_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   IssEn,
    input  logic [ADDR_W-1:0]      IssAddr,
    input  logic                   Flush,
    input  logic                   WEffA,
    input  logic [ADDR_W-1:0]      WAddrA,
    input  logic                   WEffB,
    input  logic [ADDR_W-1:0]      WAddrB,
    output logic [(1<<ADDR_W)-1:0] BusyVec
);

    localparam int unsigned c_DEPTH = 1 << ADDR_W;

    logic               w_iss;
    logic [c_DEPTH-1:0] w_next;
    logic [c_DEPTH-1:0] r_pend;

    assign w_iss = is_eff_write(IssEn, 32'(IssAddr), ZERO_REG != 0);

    // Issue beats writeback: the newly issued producer is still outstanding.
    always_comb begin
        w_next = r_pend;
        for (int r = 0; r < c_DEPTH; r++) begin
            if (Flush)
                w_next[r] = 1'b0;
            else if (w_iss && (IssAddr == ADDR_W'(r)))
                w_next[r] = 1'b1;
            else if ((WEffA && (WAddrA == ADDR_W'(r))) ||
                     (WEffB && (WAddrB == ADDR_W'(r))))
                w_next[r] = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_pend <= '0;
        else
            r_pend <= w_next;
    end

    assign BusyVec = r_pend;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Multi-port register file with two prioritised write ports,
//            write-to-read bypass, optional zero register and scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = c_DATA_W,
    parameter int unsigned ADDR_W   = c_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] RAddr,
    output logic [NUM_RD*DATA_W-1:0] RData,
    output logic [NUM_RD-1:0]        RBusy,
    input  logic                     WenA,
    input  logic [ADDR_W-1:0]        WAddrA,
    input  logic [DATA_W-1:0]        WDataA,
    input  logic                     WenB,
    input  logic [ADDR_W-1:0]        WAddrB,
    input  logic [DATA_W-1:0]        WDataB,
    input  logic                     IssEn,
    input  logic [ADDR_W-1:0]        IssAddr,
    input  logic                     Flush,
    output logic [(1<<ADDR_W)-1:0]   BusyVec,
    output logic                     Conflict
);

    localparam int unsigned c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic              r_conflict;
    logic              w_eff_a;
    logic              w_eff_b;
    logic              w_same;
    logic              w_wr_b;

    assign w_eff_a = is_eff_write(WenA, 32'(WAddrA), ZERO_REG != 0);
    assign w_eff_b = is_eff_write(WenB, 32'(WAddrB), ZERO_REG != 0);
    assign w_same  = w_eff_a && w_eff_b && (WAddrA == WAddrB);
    assign w_wr_b  = w_eff_b && !w_same;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < c_DEPTH; i++)
                r_mem[i] <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (w_eff_a)
                r_mem[WAddrA] <= WDataA;
            if (w_wr_b)
                r_mem[WAddrB] <= WDataB;
            r_conflict <= w_same;
        end
    end

    assign Conflict = r_conflict;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .Clock   (Clock),
        .Reset   (Reset),
        .IssEn   (IssEn),
        .IssAddr (IssAddr),
        .Flush   (Flush),
        .WEffA   (w_eff_a),
        .WAddrA  (WAddrA),
        .WEffB   (w_eff_b),
        .WAddrB  (WAddrB),
        .BusyVec (BusyVec)
    );

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_hit_a;
        logic              w_hit_b;

        assign w_addr  = RAddr[gi*ADDR_W +: ADDR_W];
        assign w_zero  = (ZERO_REG != 0) && (w_addr == '0);
        assign w_hit_a = (BYPASS != 0) && w_eff_a && (WAddrA == w_addr);
        assign w_hit_b = (BYPASS != 0) && w_eff_b && (WAddrB == w_addr);

        // Port A forwards ahead of B, matching the write priority.
        assign RData[gi*DATA_W +: DATA_W] = w_zero  ? '0     :
                                            w_hit_a ? WDataA :
                                            w_hit_b ? WDataB :
                                                      r_mem[w_addr];

        assign RBusy[gi] = !w_zero && !w_hit_a && !w_hit_b && BusyVec[w_addr];
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Self-checking bench for reg_file_mp (bypass and non-bypass
//            instances driven from shared write/issue stimulus).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    logic        Clock;
    logic        Reset;
    logic [7:0]  RAddr0;
    logic [11:0] RAddr1;
    logic        WenA, WenB, IssEn, Flush;
    logic [3:0]  WAddrA, WAddrB, IssAddr;
    logic [15:0] WDataA, WDataB;

    logic [31:0] RData0;
    logic [1:0]  RBusy0;
    logic [15:0] BusyVec0;
    logic        Conflict0;
    logic [47:0] RData1;
    logic [2:0]  RBusy1;
    logic [15:0] BusyVec1;
    logic        Conflict1;

    int vectors    = 0;
    int miscompares = 0;
    logic run = 1'b0;

    reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .RAddr(RAddr0), .RData(RData0), .RBusy(RBusy0),
        .WenA(WenA), .WAddrA(WAddrA), .WDataA(WDataA),
        .WenB(WenB), .WAddrB(WAddrB), .WDataB(WDataB),
        .IssEn(IssEn), .IssAddr(IssAddr), .Flush(Flush),
        .BusyVec(BusyVec0), .Conflict(Conflict0)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .RAddr(RAddr1), .RData(RData1), .RBusy(RBusy1),
        .WenA(WenA), .WAddrA(WAddrA), .WDataA(WDataA),
        .WenB(WenB), .WAddrB(WAddrB), .WDataB(WDataB),
        .IssEn(IssEn), .IssAddr(IssAddr), .Flush(Flush),
        .BusyVec(BusyVec1), .Conflict(Conflict1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [16];
    logic [15:0] m_pend;
    logic        m_conf;

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
        m_pend = 16'h0;
        m_conf = 1'b0;
    end

    function automatic logic effA(); return WenA && (WAddrA != 4'd0); endfunction
    function automatic logic effB(); return WenB && (WAddrB != 4'd0); endfunction

    function automatic logic [15:0] m_rd(input logic [3:0] a, input logic byp);
        if (a == 4'd0)                      return 16'h0;
        if (byp && effA() && WAddrA == a)   return WDataA;
        if (byp && effB() && WAddrB == a)   return WDataB;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [3:0] a, input logic byp);
        if (a == 4'd0) return 1'b0;
        if (byp && ((effA() && WAddrA == a) || (effB() && WAddrB == a))) return 1'b0;
        return m_pend[a];
    endfunction

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= 16'h0;
            m_pend <= 16'h0;
            m_conf <= 1'b0;
        end else begin
            if (effB()) m_mem[WAddrB] <= WDataB;
            if (effA()) m_mem[WAddrA] <= WDataA;
            m_conf <= effA() && effB() && (WAddrA == WAddrB);
            if (Flush) begin
                m_pend <= 16'h0;
            end else begin
                logic [15:0] p;
                p = m_pend;
                if (effA()) p[WAddrA] = 1'b0;
                if (effB()) p[WAddrB] = 1'b0;
                if (IssEn && IssAddr != 4'd0) p[IssAddr] = 1'b1;
                m_pend <= p;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge Clock) begin
        logic [3:0] a;
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                a = RAddr0[i*4 +: 4];
                chk("d0_rdata", 32'(RData0[i*16 +: 16]), 32'(m_rd(a, 1'b1)));
                chk("d0_rbusy", 32'(RBusy0[i]), 32'(m_busy(a, 1'b1)));
            end
            for (int i = 0; i < 3; i++) begin
                a = RAddr1[i*4 +: 4];
                chk("d1_rdata", 32'(RData1[i*16 +: 16]), 32'(m_rd(a, 1'b0)));
                chk("d1_rbusy", 32'(RBusy1[i]), 32'(m_busy(a, 1'b0)));
            end
            chk("d0_busyvec", 32'(BusyVec0), 32'(m_pend));
            chk("d1_busyvec", 32'(BusyVec1), 32'(m_pend));
            chk("d0_conflict", 32'(Conflict0), 32'(m_conf));
            chk("d1_conflict", 32'(Conflict1), 32'(m_conf));
        end
    end

    task automatic cyc(); @(posedge Clock); #1; endtask
    task automatic mid(); @(negedge Clock); #1; endtask

    task automatic idle();
        WenA = 1'b0; WenB = 1'b0; IssEn = 1'b0; Flush = 1'b0;
    endtask

    // ---------------- directed stimulus with literal checks ----------------
    initial begin
        Reset = 1'b0;
        idle();
        WAddrA = 4'd0; WAddrB = 4'd0; IssAddr = 4'd0;
        WDataA = 16'h0; WDataB = 16'h0;
        RAddr0 = {4'd0, 4'd3};
        RAddr1 = 12'h0;
        run = 1'b1;

        repeat (2) mid();
        chk("lit_reset_rdata", 32'(RData0[15:0]), 32'h0);
        chk("lit_reset_busyvec", 32'(BusyVec0), 32'h0);
        chk("lit_reset_conflict", 32'(Conflict0), 32'h0);

        // Release, write r3 with same-cycle read
        cyc();
        Reset = 1'b1;
        WenA = 1'b1; WAddrA = 4'd3; WDataA = 16'h1234;
        mid();
        chk("lit_bypass_r3", 32'(RData0[15:0]), 32'h1234);
        cyc(); idle();
        mid();
        chk("lit_array_r3", 32'(RData0[15:0]), 32'h1234);

        // r0 ignores write and issue
        cyc();
        WenA = 1'b1; WAddrA = 4'd0; WDataA = 16'hFFFF;
        IssEn = 1'b1; IssAddr = 4'd0;
        RAddr0 = {4'd3, 4'd0};
        mid();
        chk("lit_r0_bypass", 32'(RData0[15:0]), 32'h0);
        cyc(); idle();
        mid();
        chk("lit_r0_read", 32'(RData0[15:0]), 32'h0);
        chk("lit_r0_busy", 32'(BusyVec0[0]), 32'h0);

        // Conflicting writes to r5
        cyc();
        WenA = 1'b1; WAddrA = 4'd5; WDataA = 16'hAAAA;
        WenB = 1'b1; WAddrB = 4'd5; WDataB = 16'h5555;
        RAddr0 = {4'd5, 4'd0};
        mid();
        chk("lit_conf_bypass", 32'(RData0[31:16]), 32'hAAAA);
        chk("lit_conf_pre", 32'(Conflict0), 32'h0);
        cyc(); idle();
        mid();
        chk("lit_conf_array", 32'(RData0[31:16]), 32'hAAAA);
        chk("lit_conf_pulse", 32'(Conflict0), 32'h1);
        cyc();
        mid();
        chk("lit_conf_drop", 32'(Conflict0), 32'h0);

        // Issue r7, writeback via port B
        IssEn = 1'b1; IssAddr = 4'd7;
        RAddr0 = {4'd7, 4'd0};
        cyc(); idle();
        mid();
        chk("lit_iss_busyvec", 32'(BusyVec0[7]), 32'h1);
        chk("lit_iss_rbusy", 32'(RBusy0[1]), 32'h1);
        cyc();
        WenB = 1'b1; WAddrB = 4'd7; WDataB = 16'h0042;
        mid();
        chk("lit_wb_rbusy", 32'(RBusy0[1]), 32'h0);
        chk("lit_wb_rdata", 32'(RData0[31:16]), 32'h0042);
        cyc(); idle();
        mid();
        chk("lit_wb_clear", 32'(BusyVec0[7]), 32'h0);

        // Issue and write on the same edge: issue wins
        cyc();
        IssEn = 1'b1; IssAddr = 4'd2;
        WenA = 1'b1; WAddrA = 4'd2; WDataA = 16'h0011;
        RAddr0 = {4'd2, 4'd2};
        cyc(); idle();
        mid();
        chk("lit_iss_wins_data", 32'(RData0[15:0]), 32'h0011);
        chk("lit_iss_wins_busy", 32'(BusyVec0[2]), 32'h1);
        cyc();
        Flush = 1'b1; IssEn = 1'b1; IssAddr = 4'd9;
        cyc(); idle();
        mid();
        chk("lit_flush", 32'(BusyVec0), 32'h0);

        // Non-bypass instance: r4 shows old value until after the edge
        cyc();
        WenA = 1'b1; WAddrA = 4'd4; WDataA = 16'h0777;
        RAddr1 = {4'd4, 4'd4, 4'd4};
        mid();
        for (int i = 0; i < 3; i++)
            chk("lit_nobyp_old", 32'(RData1[i*16 +: 16]), 32'h0);
        cyc(); idle();
        mid();
        for (int i = 0; i < 3; i++)
            chk("lit_nobyp_new", 32'(RData1[i*16 +: 16]), 32'h0777);

        // Independent writes on both ports, no conflict
        cyc();
        WenA = 1'b1; WAddrA = 4'd8; WDataA = 16'h0101;
        WenB = 1'b1; WAddrB = 4'd9; WDataB = 16'h0202;
        IssEn = 1'b1; IssAddr = 4'd10;
        RAddr1 = {4'd10, 4'd9, 4'd8};
        cyc(); idle();
        mid();
        chk("lit_dual_a", 32'(RData1[15:0]), 32'h0101);
        chk("lit_dual_b", 32'(RData1[31:16]), 32'h0202);
        chk("lit_dual_noconf", 32'(Conflict1), 32'h0);
        chk("lit_dual_busy10", 32'(RBusy1[2]), 32'h1);

        // Reset asserted mid-write: the write is lost
        cyc();
        WenA = 1'b1; WAddrA = 4'd6; WDataA = 16'hBEEF;
        RAddr0 = {4'd3, 4'd6};
        RAddr1 = {4'd10, 4'd3, 4'd6};
        #2 Reset = 1'b0;
        cyc(); idle();
        Reset = 1'b1;
        mid();
        chk("lit_rst_lost", 32'(RData0[15:0]), 32'h0);
        chk("lit_rst_r3", 32'(RData0[31:16]), 32'h0);
        chk("lit_rst_busy", 32'(BusyVec1), 32'h0);

        cyc();
        mid();
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
